aardvark_ctrl_fsm: RTL and testbench
====================================

Name: aardvark_ctrl_fsm

Overview:
- Multi-cycle control unit for the Aardvark 8-bit CPU.
- Fetches each 8-bit instruction over a ready-handshaked memory port, holds it in an internal IR and sequences datapath control (PC, ALU, register file, memory, immediate select) through fetch/decode/execute/mem/writeback.
- The sign-extended 2-bit immediate path is selected by imm_sel.
- Includes a memory-wait watchdog that halts on bus timeout.

Parameters:
- MAX_WAIT, 15, wait cycles allowed for mem_ready before bus error (1..2^WAIT_W-1)
- WAIT_W, 4, width of the wait counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin execution from IDLE
- mem_ready  in  1  memory completes the current request this cycle
- mem_rdata  in  8  read data (instruction during FETCH)
- zero_flag  in  1  ALU zero result, valid in EXEC
- ir  out  8  instruction register: opcode [7:4], rs [3:2], rt/imm2 [1:0]
- mem_req  out  1  memory request active
- mem_we  out  1  write strobe (sw only)
- addr_sel  out  1  0 = PC, 1 = ALU result
- pc_inc  out  1  PC <= PC+1
- pc_load_br  out  1  PC <= PC + sign-extended imm2
- pc_load_jmp  out  1  PC <= {ir[3:0],4'b0}
- imm_sel  out  1  ALU B = sign-extended imm2
- alu_op  out  2  00 add, 01 sub, 10 and, 11 or
- reg_we  out  1  register file write
- wb_sel  out  1  0 = ALU, 1 = mem_rdata
- halted  out  1  core halted
- illegal  out  1  one-cycle pulse on undefined opcode
- bus_err  out  1  sticky memory timeout flag
- state  out  3  current state encoding, for debug

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ir=8'h00, wait counter=0, bus_err=0. All strobes are 0 while in reset.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Code 7 is unreachable and recovers to IDLE.
- Outputs are decoded from state and ir. ir_load/pc_inc are additionally gated by mem_ready (Mealy). All other outputs are Moore.
- IDLE: all strobes 0. start=1 moves to FETCH next cycle. start is ignored in every other state.
- FETCH: mem_req=1, addr_sel=0. When mem_ready=1: ir <= mem_rdata, pc_inc=1 that cycle, go to DECODE. Otherwise hold and increment the wait counter.
- DECODE: one cycle, no strobes.
  - Opcode 4'hF goes to HALT.
  - Opcodes 4'h9..4'hE pulse illegal=1 and go to FETCH (treated as NOP).
  - All others go to EXEC.
- EXEC:
  - 0..3 (add/sub/and/or): alu_op = opcode[1:0], imm_sel=0, go to WB.
  - 4 (addi): alu_op=00, imm_sel=1, go to WB.
  - 5 (lw) and 6 (sw): alu_op=00, imm_sel=1, go to MEM.
  - 7 (beq): alu_op=01, pc_load_br = zero_flag, go to FETCH.
  - 8 (jmp): pc_load_jmp=1, go to FETCH.
- MEM: mem_req=1, addr_sel=1, mem_we = (opcode==6). On mem_ready: lw goes to WB, sw goes to FETCH.
- WB: reg_we=1, wb_sel = (opcode==5), go to FETCH.
- HALT: halted=1, all strobes 0, remain here until reset.
- Wait counter:
  - Cleared on entry to FETCH/MEM and on any mem_ready.
  - In FETCH/MEM, when it equals MAX_WAIT and mem_ready=0: set bus_err, go to HALT.
  - If mem_ready and the timeout coincide, mem_ready wins and no error is raised.
- Latency per instruction, with 0-wait memory:
  - R-type and addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq and jmp: 3 cycles.

Decomposition:
- Shared package/include (aardvark_defs): opcode constants, state encodings, alu_op codes.
- Natural sub-module: aardvark_wait_timer (wait counter + timeout compare, parameterised by MAX_WAIT/WAIT_W).

Test Plan:
- Reset release, start=1, mem_ready=1 every cycle, instruction 8'h06 (add r1,r2): states 1→2→3→5→1. reg_we=1 for exactly one cycle in WB, alu_op=00, pc_inc=1 once.
- lw 8'h57 with mem_ready delayed 3 cycles in MEM: mem_req held for 4 cycles with addr_sel=1, then WB with wb_sel=1 and reg_we=1. bus_err stays 0.
- beq 8'h73 with zero_flag=1 → pc_load_br=1 and imm_sel=0; repeat with zero_flag=0 → pc_load_br=0. Both return to FETCH after 3 cycles.
- Illegal opcode 8'hA0 → illegal pulses for 1 cycle in DECODE, next state FETCH, no reg_we/mem_we.
- mem_ready held 0 in FETCH: after MAX_WAIT=15 wait cycles bus_err=1 and halted=1, both persisting. Ready arriving on the 15th cycle instead produces no error.
- 8'hF0 → HALT, halted=1. Then assert rst_n=0 mid-HALT, then mid-MEM: state=0, ir=00, bus_err=0 immediately (asynchronous), and start restarts fetch.

Source files
------------

// File: rtl/aardvark_defs.sv
// Shared definitions for the Aardvark control unit: state encodings,
// opcodes and ALU operation codes.
package aardvark_defs;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Opcodes 9..E are undefined and executed as a NOP with an illegal pulse.
  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'h9) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/aardvark_wait_timer.sv
// Memory-wait watchdog: counts stalled cycles while a request is pending
// and flags a timeout once MAX_WAIT stalls have elapsed without mem_ready.
module aardvark_wait_timer #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] cnt_reg;
  logic [WAIT_W-1:0] cnt_next;

  // Idle outside FETCH/MEM keeps the count at zero, so every new request starts fresh.
  always_comb begin
    cnt_next = cnt_reg;
    if (!active || mem_ready) begin
      cnt_next = '0;
    end else if (cnt_reg != LIMIT) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // A ready arriving on the limit cycle wins over the timeout.
  assign timeout = active && !mem_ready && (cnt_reg == LIMIT);

endmodule

// File: rtl/aardvark_ctrl_fsm.sv
// Multi-cycle control FSM for the Aardvark 8-bit CPU: fetch, decode,
// execute, memory and writeback sequencing with a bus-timeout halt.
module aardvark_ctrl_fsm
  import aardvark_defs::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mem_ready,
  input  logic [7:0] mem_rdata,
  input  logic       zero_flag,
  output logic [7:0] ir,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       pc_inc,
  output logic       pc_load_br,
  output logic       pc_load_jmp,
  output logic       imm_sel,
  output logic [1:0] alu_op,
  output logic       reg_we,
  output logic       wb_sel,
  output logic       halted,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
);

  state_t     state_reg;
  state_t     state_next;
  logic [7:0] ir_reg;
  logic       bus_err_reg;
  logic       ir_load;
  logic       timeout;
  logic       wait_active;
  logic [3:0] opcode;

  assign opcode      = ir_reg[7:4];
  assign wait_active = (state_reg == ST_FETCH) || (state_reg == ST_MEM);

  aardvark_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .active    (wait_active),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      ir_reg      <= 8'h00;
      bus_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (ir_load) begin
        ir_reg <= mem_rdata;
      end
      if (timeout) begin
        bus_err_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    ir_load     = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    pc_inc      = 1'b0;
    pc_load_br  = 1'b0;
    pc_load_jmp = 1'b0;
    imm_sel     = 1'b0;
    alu_op      = ALU_ADD;
    reg_we      = 1'b0;
    wb_sel      = 1'b0;
    halted      = 1'b0;
    illegal     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_FETCH;
        end
      end

      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          state_next = ST_DECODE;
        end else if (timeout) begin
          state_next = ST_HALT;
        end
      end

      ST_DECODE: begin
        if (opcode == OP_HALT) begin
          state_next = ST_HALT;
        end else if (is_illegal(opcode)) begin
          illegal    = 1'b1;
          state_next = ST_FETCH;
        end else begin
          state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            alu_op     = opcode[1:0];
            state_next = ST_WB;
          end
          OP_ADDI: begin
            imm_sel    = 1'b1;
            state_next = ST_WB;
          end
          OP_LW, OP_SW: begin
            imm_sel    = 1'b1;
            state_next = ST_MEM;
          end
          OP_BEQ: begin
            alu_op     = ALU_SUB;
            pc_load_br = zero_flag;
            state_next = ST_FETCH;
          end
          OP_JMP: begin
            pc_load_jmp = 1'b1;
            state_next  = ST_FETCH;
          end
          default: begin
            state_next = ST_FETCH;
          end
        endcase
      end

      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (opcode == OP_SW);
        if (mem_ready) begin
          state_next = (opcode == OP_LW) ? ST_WB : ST_FETCH;
        end else if (timeout) begin
          state_next = ST_HALT;
        end
      end

      ST_WB: begin
        reg_we     = 1'b1;
        wb_sel     = (opcode == OP_LW);
        state_next = ST_FETCH;
      end

      ST_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign ir      = ir_reg;
  assign bus_err = bus_err_reg;
  assign state   = state_reg;

endmodule

// File: tb/tb_aardvark_ctrl_fsm.sv
// Self-checking bench for aardvark_ctrl_fsm: directed scenarios plus a
// randomized instruction stream checked against a per-instruction model.
module tb_aardvark_ctrl_fsm;

  localparam int MAXW = 15;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mem_ready = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic       zero_flag = 1'b0;
  logic [7:0] ir;
  logic       mem_req, mem_we, addr_sel, pc_inc, pc_load_br, pc_load_jmp;
  logic       imm_sel, reg_we, wb_sel, halted, illegal, bus_err;
  logic [1:0] alu_op;
  logic [2:0] state;

  int total = 0;
  int bad = 0;
  bit start_noise = 0;
  logic [2:0] trace[$];

  // Per-instruction summary: strobe cycle counts and end-of-instruction status.
  typedef struct packed {
    logic [7:0] cycles;
    logic [7:0] reg_we;
    logic [7:0] mem_we;
    logic [7:0] pc_inc;
    logic [7:0] illegal;
    logic [7:0] br;
    logic [7:0] jmp;
    logic [7:0] imm;
    logic [7:0] wbsel;
    logic [7:0] memreq_a1;
    logic [1:0] alu_exec;
    logic [7:0] ir;
    logic [2:0] end_state;
    logic       bus_err;
    logic       halted;
    logic       to;
  } obs_t;

  aardvark_ctrl_fsm dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .zero_flag   (zero_flag),
    .ir          (ir),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .addr_sel    (addr_sel),
    .pc_inc      (pc_inc),
    .pc_load_br  (pc_load_br),
    .pc_load_jmp (pc_load_jmp),
    .imm_sel     (imm_sel),
    .alu_op      (alu_op),
    .reg_we      (reg_we),
    .wb_sel      (wb_sel),
    .halted      (halted),
    .illegal     (illegal),
    .bus_err     (bus_err),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Expected summary of one instruction derived from the instruction-class rules.
  function automatic obs_t model(input logic [7:0] instr, input int fw, input int mw, input bit zf);
    obs_t e;
    logic [3:0] op;
    e = '0;
    op = instr[7:4];
    if (fw > MAXW) begin
      e.cycles = 8'(MAXW + 1);
      e.end_state = S_HALT;
      e.bus_err = 1'b1;
      e.halted = 1'b1;
      return e;
    end
    e.pc_inc = 8'd1;
    e.ir = instr;
    e.cycles = 8'(fw + 2);
    e.end_state = S_FETCH;
    if (op == 4'hF) begin
      e.end_state = S_HALT;
      e.halted = 1'b1;
    end else if (op >= 4'h9) begin
      e.illegal = 8'd1;
    end else begin
      e.cycles = e.cycles + 8'd1;
      if (op <= 4'h3) begin
        e.alu_exec = op[1:0];
        e.reg_we = 8'd1;
        e.cycles = e.cycles + 8'd1;
      end else if (op == 4'h4) begin
        e.imm = 8'd1;
        e.reg_we = 8'd1;
        e.cycles = e.cycles + 8'd1;
      end else if (op == 4'h5 || op == 4'h6) begin
        e.imm = 8'd1;
        if (mw > MAXW) begin
          e.cycles = e.cycles + 8'(MAXW + 1);
          e.memreq_a1 = 8'(MAXW + 1);
          if (op == 4'h6) e.mem_we = 8'(MAXW + 1);
          e.end_state = S_HALT;
          e.bus_err = 1'b1;
          e.halted = 1'b1;
        end else begin
          e.cycles = e.cycles + 8'(mw + 1);
          e.memreq_a1 = 8'(mw + 1);
          if (op == 4'h6) begin
            e.mem_we = 8'(mw + 1);
          end else begin
            e.reg_we = 8'd1;
            e.wbsel = 8'd1;
            e.cycles = e.cycles + 8'd1;
          end
        end
      end else if (op == 4'h7) begin
        e.alu_exec = 2'b01;
        e.br = 8'(zf);
      end else begin
        e.jmp = 8'd1;
      end
    end
    return e;
  endfunction

  // Runs one instruction from FETCH with a memory that answers after fw/mw stall cycles.
  task automatic run_instr(input logic [7:0] instr, input int fw, input int mw, input bit zf, output obs_t o);
    int req_cnt;
    bit left_fetch;
    bit done;
    o = '0;
    req_cnt = 0;
    left_fetch = 0;
    done = 0;
    trace.delete();
    mem_rdata = instr;
    zero_flag = zf;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      mem_ready = mem_req && (req_cnt == (addr_sel ? mw : fw));
      if (start_noise) start = 1'($urandom_range(0, 1));
      #1;
      trace.push_back(state);
      o.cycles = o.cycles + 8'd1;
      if (reg_we) o.reg_we = o.reg_we + 8'd1;
      if (mem_we) o.mem_we = o.mem_we + 8'd1;
      if (pc_inc) o.pc_inc = o.pc_inc + 8'd1;
      if (illegal) o.illegal = o.illegal + 8'd1;
      if (pc_load_br) o.br = o.br + 8'd1;
      if (pc_load_jmp) o.jmp = o.jmp + 8'd1;
      if (imm_sel) o.imm = o.imm + 8'd1;
      if (wb_sel) o.wbsel = o.wbsel + 8'd1;
      if (mem_req && addr_sel) o.memreq_a1 = o.memreq_a1 + 8'd1;
      if (state == S_EXEC) o.alu_exec = alu_op;
      if (state == S_DECODE) o.ir = ir;
      if (mem_req) req_cnt = mem_ready ? 0 : req_cnt + 1;
      if (pc_inc) left_fetch = 1;
      @(posedge clk);
      #1;
      if ((state == S_FETCH && left_fetch) || state == S_HALT) begin
        done = 1;
        break;
      end
    end
    mem_ready = 1'b0;
    start = 1'b0;
    o.to = !done;
    o.end_state = state;
    o.bus_err = bus_err;
    o.halted = halted;
    $display("instr %h fw=%0d mw=%0d zf=%0d cycles=%0d end_state=%0d", instr, fw, mw, zf, o.cycles, o.end_state);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (state !== S_IDLE || ir !== 8'h00 || bus_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: state=%0d ir=%h bus_err=%b, want 0/00/0", state, ir, bus_err);
    end
    total++;
    if ({mem_req, mem_we, pc_inc, reg_we, halted, illegal, pc_load_br, pc_load_jmp} !== 8'h00) begin
      bad++;
      $display("FAIL reset_strobes: req=%b we=%b inc=%b rwe=%b hlt=%b ill=%b, want all 0",
               mem_req, mem_we, pc_inc, reg_we, halted, illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (state !== S_IDLE || mem_req !== 1'b0) begin
        bad++;
        $display("FAIL idle_hold: state=%0d mem_req=%b, want 0/0", state, mem_req);
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_add();
    obs_t o, e;
    logic [2:0] exp_tr[$];
    bit ok;
    do_start();
    run_instr(8'h06, 0, 0, 1'b0, o);
    e = model(8'h06, 0, 0, 1'b0);
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL add_summary: got %h want %h", o, e);
    end
    exp_tr = '{S_FETCH, S_DECODE, S_EXEC, S_WB};
    ok = (trace.size() == exp_tr.size());
    for (int i = 0; i < exp_tr.size(); i++) begin
      if (ok && trace[i] !== exp_tr[i]) ok = 0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL add_trace: got %p want 1,2,3,5", trace);
    end
  endtask

  task automatic test_lw();
    obs_t o, e;
    run_instr(8'h57, 0, 3, 1'b0, o);
    e = model(8'h57, 0, 3, 1'b0);
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL lw_wait3: got %h want %h", o, e);
    end
  endtask

  task automatic test_beq();
    obs_t o, e;
    for (int z = 1; z >= 0; z--) begin
      run_instr(8'h73, 0, 0, 1'(z), o);
      e = model(8'h73, 0, 0, 1'(z));
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL beq_zf%0d: got %h want %h", z, o, e);
      end
    end
  endtask

  task automatic test_illegal();
    obs_t o, e;
    run_instr(8'hA0, 0, 0, 1'b0, o);
    e = model(8'hA0, 0, 0, 1'b0);
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL illegal_a0: got %h want %h", o, e);
    end
  endtask

  task automatic test_timeout();
    obs_t o, e;
    run_instr(8'h06, 99, 0, 1'b0, o);
    e = model(8'h06, 99, 0, 1'b0);
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL fetch_timeout: got %h want %h", o, e);
    end
    mem_ready = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (state !== S_HALT || halted !== 1'b1 || bus_err !== 1'b1) begin
        bad++;
        $display("FAIL timeout_sticky: state=%0d halted=%b bus_err=%b, want 6/1/1", state, halted, bus_err);
      end
    end
    start = 1'b0;
    apply_reset();
    #1;
    total++;
    if (bus_err !== 1'b0) begin
      bad++;
      $display("FAIL bus_err_clear: got %b want 0", bus_err);
    end
    do_start();
    for (int fw = MAXW - 1; fw <= MAXW; fw++) begin
      run_instr(8'h06, fw, 0, 1'b0, o);
      e = model(8'h06, fw, 0, 1'b0);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL fetch_ready_edge fw=%0d: got %h want %h", fw, o, e);
      end
    end
    run_instr(8'h57, 0, MAXW, 1'b0, o);
    e = model(8'h57, 0, MAXW, 1'b0);
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL mem_ready_edge: got %h want %h", o, e);
    end
    run_instr(8'h61, 2, 99, 1'b0, o);
    e = model(8'h61, 2, 99, 1'b0);
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL mem_timeout_sw: got %h want %h", o, e);
    end
  endtask

  task automatic test_halt_reset();
    obs_t o, e;
    bit hit;
    apply_reset();
    do_start();
    run_instr(8'hF0, 1, 0, 1'b0, o);
    e = model(8'hF0, 1, 0, 1'b0);
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL halt_op: got %h want %h", o, e);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (state !== S_IDLE || ir !== 8'h00 || halted !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_halt: state=%0d ir=%h halted=%b, want 0/00/0", state, ir, halted);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_start();
    mem_rdata = 8'h57;
    @(negedge clk);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    hit = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (state == S_MEM) begin
        hit = 1;
        break;
      end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL reach_mem: state=%0d want 4 within 10 cycles", state);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (state !== S_IDLE || ir !== 8'h00 || bus_err !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_mem: state=%0d ir=%h bus_err=%b mem_req=%b, want 0/00/0/0",
               state, ir, bus_err, mem_req);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_start();
    total++;
    if (state !== S_FETCH || mem_req !== 1'b1) begin
      bad++;
      $display("FAIL restart_fetch: state=%0d mem_req=%b, want 1/1", state, mem_req);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    logic [7:0] instr;
    int fw, mw;
    bit zf;
    start_noise = 1;
    for (int n = 0; n < 40; n++) begin
      instr = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
      fw = $urandom_range(0, MAXW);
      mw = $urandom_range(0, MAXW);
      zf = 1'($urandom_range(0, 1));
      run_instr(instr, fw, mw, zf, o);
      e = model(instr, fw, mw, zf);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL random_%0d instr=%h: got %h want %h", n, instr, o, e);
      end
    end
    start_noise = 0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_beq();
    test_illegal();
    test_back_to_back();
    test_timeout();
    test_halt_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
